// File: rtl/stopwatch_ctrl_if.sv
// Command/status bundle between the front-panel decoder, the stopwatch controller and the display mux.
// The decoder side drives commands and alarm settings; the controller drives time, lap and status.
interface stopwatch_ctrl_if;
  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_clear;
  logic       cmd_lap;
  logic       alarm_en;
  logic [5:0] alarm_min;
  logic [5:0] alarm_sec;
  logic       alarm_ack;

  logic       sec_tick;
  logic [5:0] second;
  logic [5:0] minute;
  logic [5:0] lap_sec;
  logic [5:0] lap_min;
  logic       lap_valid;
  logic       running;
  logic       alarm;
  logic       overflow;

  modport master (
    output cmd_start, cmd_stop, cmd_clear, cmd_lap,
    output alarm_en, alarm_min, alarm_sec, alarm_ack,
    input  sec_tick, second, minute, lap_sec, lap_min,
    input  lap_valid, running, alarm, overflow
  );

  modport slave (
    input  cmd_start, cmd_stop, cmd_clear, cmd_lap,
    input  alarm_en, alarm_min, alarm_sec, alarm_ack,
    output sec_tick, second, minute, lap_sec, lap_min,
    output lap_valid, running, alarm, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear controller: 1 s prescaler, command FSM, mm:ss counter, lap, alarm, overflow.
// All outputs registered; commands take effect on the edge they are sampled.
module stopwatch_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50,
  parameter int unsigned MAX_MIN       = 59
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave sw
);

  localparam int unsigned   PW        = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_END = PW'(TICKS_PER_SEC - 1);
  localparam logic [5:0]    MIN_END   = 6'(MAX_MIN);
  localparam logic [5:0]    SEC_END   = 6'd59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    lap_sec_q, lap_sec_d;
  logic [5:0]    lap_min_q, lap_min_d;
  logic          tick_q, tick_d;
  logic          lap_vld_q, lap_vld_d;
  logic          running_q, running_d;
  logic          alarm_q, alarm_d;
  logic          ovf_q, ovf_d;

  logic tick_due;
  logic at_max;

  assign tick_due = (state_q == RUN) && (presc_q == PRESC_END);
  assign at_max   = (sec_q == SEC_END) && (min_q == MIN_END);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    sec_d     = sec_q;
    min_d     = min_q;
    lap_sec_d = lap_sec_q;
    lap_min_d = lap_min_q;
    tick_d    = 1'b0;
    lap_vld_d = 1'b0;
    alarm_d   = alarm_q;
    ovf_d     = ovf_q;

    if (sw.cmd_clear) begin
      state_d = IDLE;
      presc_d = '0;
      sec_d   = '0;
      min_d   = '0;
      alarm_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (sw.alarm_ack) begin
        alarm_d = 1'b0;
      end

      // Prescaler keeps counting on the stop edge, so a resume continues the same phase.
      if (state_q == RUN) begin
        if (tick_due) begin
          presc_d = '0;
          if (at_max) begin
            ovf_d = 1'b1;
          end else begin
            tick_d = 1'b1;
            if (sec_q == SEC_END) begin
              sec_d = '0;
              min_d = min_q + 6'd1;
            end else begin
              sec_d = sec_q + 6'd1;
            end
            if (sw.alarm_en && (sec_d == sw.alarm_sec) && (min_d == sw.alarm_min)) begin
              alarm_d = 1'b1;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      unique case (state_q)
        IDLE: begin
          if (sw.cmd_start && !sw.cmd_stop) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (tick_due && at_max) begin
            state_d = DONE;
          end else if (sw.cmd_stop) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (sw.cmd_start && !sw.cmd_stop) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // Lap samples the pre-advance time of this edge.
      if (sw.cmd_lap && (state_q != IDLE)) begin
        lap_sec_d = sec_q;
        lap_min_d = min_q;
        lap_vld_d = 1'b1;
      end
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      lap_sec_q <= '0;
      lap_min_q <= '0;
      tick_q    <= 1'b0;
      lap_vld_q <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      lap_sec_q <= lap_sec_d;
      lap_min_q <= lap_min_d;
      tick_q    <= tick_d;
      lap_vld_q <= lap_vld_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
      ovf_q     <= ovf_d;
    end
  end

  assign sw.sec_tick  = tick_q;
  assign sw.second    = sec_q;
  assign sw.minute    = min_q;
  assign sw.lap_sec   = lap_sec_q;
  assign sw.lap_min   = lap_min_q;
  assign sw.lap_valid = lap_vld_q;
  assign sw.running   = running_q;
  assign sw.alarm     = alarm_q;
  assign sw.overflow  = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICKS_PER_SEC=4, MAX_MIN=1.
module tb_stopwatch_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .TICKS_PER_SEC(4),
    .MAX_MIN      (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; returns 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    sw_if.cmd_start = 1'b0;
    sw_if.cmd_stop  = 1'b0;
    sw_if.cmd_clear = 1'b0;
    sw_if.cmd_lap   = 1'b0;
    sw_if.alarm_en  = 1'b0;
    sw_if.alarm_min = 6'd0;
    sw_if.alarm_sec = 6'd0;
    sw_if.alarm_ack = 1'b0;

    step(2);
    chk1("rst_running",  sw_if.running,   1'b0);
    chk1("rst_tick",     sw_if.sec_tick,  1'b0);
    chk6("rst_second",   sw_if.second,    6'd0);
    chk6("rst_minute",   sw_if.minute,    6'd0);
    chk1("rst_alarm",    sw_if.alarm,     1'b0);
    chk1("rst_overflow", sw_if.overflow,  1'b0);
    chk1("rst_lapvld",   sw_if.lap_valid, 1'b0);
    rst = 1'b0;
    step(1);

    // Alarm at 0:03 armed before starting.
    sw_if.alarm_en  = 1'b1;
    sw_if.alarm_sec = 6'd3;

    // Start at edge c0.
    sw_if.cmd_start = 1'b1;
    step(1);
    sw_if.cmd_start = 1'b0;
    chk1("start_running", sw_if.running,  1'b1);
    chk6("start_second",  sw_if.second,   6'd0);
    step(3);
    chk1("c3_no_tick",    sw_if.sec_tick, 1'b0);
    chk6("c3_second",     sw_if.second,   6'd0);
    step(1);
    chk1("c4_tick",       sw_if.sec_tick, 1'b1);
    chk6("c4_second",     sw_if.second,   6'd1);
    step(1);
    chk1("c5_tick_low",   sw_if.sec_tick, 1'b0);
    step(3);
    chk1("c8_tick",       sw_if.sec_tick, 1'b1);
    chk6("c8_second",     sw_if.second,   6'd2);
    chk1("c8_alarm_low",  sw_if.alarm,    1'b0);
    step(4);
    chk6("c12_second",    sw_if.second,   6'd3);
    chk1("c12_alarm_set", sw_if.alarm,    1'b1);

    // Re-arm at 0:05 and ack on the matching edge: set wins.
    sw_if.alarm_sec = 6'd5;
    step(7);
    sw_if.alarm_ack = 1'b1;
    step(1);
    chk6("c20_second",     sw_if.second, 6'd5);
    chk1("c20_alarm_hold", sw_if.alarm,  1'b1);
    step(1);
    sw_if.alarm_ack = 1'b0;
    chk1("c21_alarm_ack",  sw_if.alarm,  1'b0);
    sw_if.alarm_en = 1'b0;

    // Lap on the 0:05 -> 0:06 tick edge (c24).
    step(2);
    sw_if.cmd_lap = 1'b1;
    step(1);
    sw_if.cmd_lap = 1'b0;
    chk6("lap_now_second", sw_if.second,    6'd6);
    chk1("lap_now_tick",   sw_if.sec_tick,  1'b1);
    chk6("lap_sec",        sw_if.lap_sec,   6'd5);
    chk6("lap_min",        sw_if.lap_min,   6'd0);
    chk1("lap_valid_hi",   sw_if.lap_valid, 1'b1);
    step(1);
    chk1("lap_valid_lo",   sw_if.lap_valid, 1'b0);

    // Pause at c26 (prescaler 1->2), hold 10 cycles, resume: tick 2 cycles later.
    sw_if.cmd_stop = 1'b1;
    step(1);
    sw_if.cmd_stop = 1'b0;
    chk1("pause_running", sw_if.running, 1'b0);
    step(10);
    chk6("pause_second",  sw_if.second,  6'd6);
    chk1("pause_tick",    sw_if.sec_tick, 1'b0);
    sw_if.cmd_start = 1'b1;
    step(1);
    sw_if.cmd_start = 1'b0;
    chk1("resume_running", sw_if.running, 1'b1);
    step(1);
    chk1("resume_r1_tick", sw_if.sec_tick, 1'b0);
    step(1);
    chk1("resume_r2_tick", sw_if.sec_tick, 1'b1);
    chk6("resume_second",  sw_if.second,   6'd7);

    // Run to 0:59, then minute rollover on the next tick.
    step(52 * 4);
    chk6("s59_second", sw_if.second, 6'd59);
    chk6("s59_minute", sw_if.minute, 6'd0);
    step(4);
    chk1("roll_tick",   sw_if.sec_tick, 1'b1);
    chk6("roll_second", sw_if.second,   6'd0);
    chk6("roll_minute", sw_if.minute,   6'd1);

    // Run to 1:59, then the due tick overflows instead of advancing.
    step(59 * 4);
    chk6("m1s59_second",  sw_if.second,   6'd59);
    chk6("m1s59_minute",  sw_if.minute,   6'd1);
    chk1("m1s59_ovf",     sw_if.overflow, 1'b0);
    step(4);
    chk1("ovf_set",       sw_if.overflow, 1'b1);
    chk1("ovf_tick",      sw_if.sec_tick, 1'b0);
    chk1("ovf_running",   sw_if.running,  1'b0);
    chk6("ovf_second",    sw_if.second,   6'd59);
    chk6("ovf_minute",    sw_if.minute,   6'd1);
    step(8);
    chk6("held_second",   sw_if.second,   6'd59);
    chk6("held_minute",   sw_if.minute,   6'd1);
    chk1("held_tick",     sw_if.sec_tick, 1'b0);

    sw_if.cmd_clear = 1'b1;
    step(1);
    sw_if.cmd_clear = 1'b0;
    chk6("clr_second",   sw_if.second,   6'd0);
    chk6("clr_minute",   sw_if.minute,   6'd0);
    chk1("clr_overflow", sw_if.overflow, 1'b0);
    chk1("clr_running",  sw_if.running,  1'b0);

    // Lap in IDLE is ignored.
    sw_if.cmd_lap = 1'b1;
    step(1);
    sw_if.cmd_lap = 1'b0;
    chk1("idle_lap_vld", sw_if.lap_valid, 1'b0);

    // stop+start+clear in the same cycle while running: clear wins.
    sw_if.cmd_start = 1'b1;
    step(1);
    sw_if.cmd_start = 1'b0;
    step(5);
    chk6("pre_sss_second", sw_if.second, 6'd1);
    sw_if.cmd_start = 1'b1;
    sw_if.cmd_stop  = 1'b1;
    sw_if.cmd_clear = 1'b1;
    step(1);
    sw_if.cmd_start = 1'b0;
    sw_if.cmd_stop  = 1'b0;
    sw_if.cmd_clear = 1'b0;
    chk1("sss_running", sw_if.running, 1'b0);
    chk6("sss_second",  sw_if.second,  6'd0);
    step(6);
    chk6("sss_idle_second", sw_if.second,   6'd0);
    chk1("sss_idle_tick",   sw_if.sec_tick, 1'b0);

    // Asynchronous reset while running with a lap captured.
    sw_if.cmd_start = 1'b1;
    step(1);
    sw_if.cmd_start = 1'b0;
    step(5);
    sw_if.cmd_lap = 1'b1;
    step(1);
    sw_if.cmd_lap = 1'b0;
    chk6("pre_rst_lap_sec", sw_if.lap_sec, 6'd1);
    chk1("pre_rst_running", sw_if.running, 1'b1);
    rst = 1'b1;
    #2;
    chk1("arst_running", sw_if.running,   1'b0);
    chk6("arst_second",  sw_if.second,    6'd0);
    chk6("arst_lap_sec", sw_if.lap_sec,   6'd0);
    chk1("arst_lapvld",  sw_if.lap_valid, 1'b0);
    rst = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
